frame_tick_generator: RTL and testbench
=======================================

Name: frame_tick_generator

Overview:
- Parametrised game-tick source for the VGA pixel-clock domain. Emits a single-cycle `tick` enable rather than a gated clock.
- Run mode: `tick` fires once every (`frame_div`+1) end-of-frame events.
- Step mode: `tick` fires once per debounced key press.
- Sits between the VGA timing block and all game-state logic, which advances only on `tick`.

Parameters:
- COORD_W, 10, width of pixel coordinates
- H_LAST, 639, last visible x coordinate
- V_LAST, 479, last visible y coordinate
- DIV_W, 4, width of the `frame_div` input and the divider counter
- DEBOUNCE_CYCLES, 250000, clock cycles a key level must hold before it is accepted (>=2)
- CNT_W, 16, width of `tick_count`
- REPEAT_DELAY, 30, frame events a held key waits before autorepeat starts (optional feature only)

Ports:
- clk  in  1  pixel-domain clock
- rst_n  in  1  reset; asynchronous assert, active-low
- step_mode_sw  in  1  async switch; 1 = step mode, 0 = run mode
- key_n  in  1  async push-button, active-low
- pause  in  1  synchronous; 1 suppresses all ticks
- pixel_x  in  COORD_W  current pixel x
- pixel_y  in  COORD_W  current pixel y
- frame_div  in  DIV_W  run-mode divider; 0 = tick every frame
- tick  out  1  registered single-cycle advance enable
- tick_count  out  CNT_W  total ticks issued, wraps
- mode_is_step  out  1  registered, debounced current mode

Behaviour:
- Reset (`rst_n`=0, async): `tick`=0, `tick_count`=0, `mode_is_step`=0, FSM=RUN, divider=0.
  - `key_n` synchronisers and stable level reset to 1 (released); switch synchroniser resets to 0.
- Synchronisers: `key_n` and `step_mode_sw` each pass through 2 flops.
- Debounce (`key_n` only):
  - Counter increments while the synced level differs from the stable level; it clears when the two are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1, the stable level takes the synced level and the counter clears.
  - press = stable level 1->0.
- Frame event:
  - frame_end = (`pixel_x`==H_LAST && `pixel_y`==V_LAST).
  - event = frame_end & ~frame_end_q, so a coordinate held for several clocks gives exactly one event.
- FSM states: RUN, STEP_IDLE, STEP_HELD.
  - RUN -> STEP_IDLE when synced switch =1.
  - STEP_* -> RUN when synced switch =0.
  - STEP_IDLE -> STEP_HELD on press.
  - STEP_HELD -> STEP_IDLE when the stable level returns to 1.
  - `mode_is_step` = (state != RUN), registered.
- Any mode change clears the divider. No tick is issued in the cycle the state changes.
- RUN tick rules:
  - On event: if divider >= `frame_div`, assert tick next cycle and clear divider; else divider+1.
  - `frame_div` may change at any time. `>=` guarantees a tick on the next event if the divider is already above the new value.
- STEP tick rule: press in STEP_IDLE asserts tick next cycle. Frame events are ignored.
- Latency: exactly 1 clock from event/press detection to `tick`=1. `tick` is high for exactly 1 cycle.
- `pause`=1:
  - No tick; divider frozen.
  - A press while paused still moves STEP_IDLE->STEP_HELD but produces no tick and is not queued.
  - Debounce and the FSM keep running.
- Simultaneous event and press in the same cycle: only the current state's source counts.
- `tick_count` increments on every tick and wraps 2^CNT_W-1 -> 0.
- Reset mid-debounce or mid-divide: all counters return to 0 immediately. No tick in the cycle after release.

Optional Feature:
- Macro: FRAME_TICK_AUTOREPEAT_EN
- With the macro:
  - In STEP_HELD a hold counter counts frame events.
  - After REPEAT_DELAY events, every subsequent frame event issues a tick (1-cycle latency; suppressed by `pause`).
  - The hold counter clears on leaving STEP_HELD and saturates at REPEAT_DELAY.
- Without the macro: exactly one tick per press. No hold counter exists and REPEAT_DELAY is unused.

Decomposition:
- Shared package `tick_gen_pkg` holds:
  - the FSM state typedef (RUN, STEP_IDLE, STEP_HELD);
  - default localparams for the 640x480 last pixel and default DEBOUNCE_CYCLES at 25 MHz.
- One sub-module: `key_debouncer`, containing the 2-flop synchroniser, debounce counter, stable level and a press pulse output. It is parametrised by DEBOUNCE_CYCLES and reset level.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=3):
- Run, `frame_div`=0, pixel at (639,479) for 1 clk every 1000 clks -> tick once per frame, 1 clk after the match; `tick_count`=5 after 5 frames.
- Run, `frame_div`=2, coordinate held 4 clks per frame -> ticks on frames 3, 6, 9 only, each 1 cycle wide.
- Step: `key_n` bounces 1-0-1-0 every clk, then holds 0 for 10 clks -> exactly one tick, ~2+4 clks after the stable 0; no tick on release.
- Switch to step mid-divide (divider=1), then back to run -> no tick at either transition; first run tick after `frame_div`+1 events.
- `pause`=1 during 3 frames and one press -> no ticks, divider unchanged; after `pause`=0 the next tick arrives on schedule.
- With FRAME_TICK_AUTOREPEAT_EN, key held for 6 frames -> 1 press tick, then ticks on frames 4, 5, 6; without the macro, 1 tick only.

Source files
------------

// File: rtl/tick_gen_pkg.sv
// Shared types and default constants for the frame tick generator.
package tick_gen_pkg;

  localparam int unsigned H_LAST_DEF          = 32'd639;
  localparam int unsigned V_LAST_DEF          = 32'd479;
  // 10 ms of key stability at a 25 MHz pixel clock
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 32'd250000;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    STEP_IDLE = 2'd1,
    STEP_HELD = 2'd2
  } tick_state_e;

  function automatic logic is_step_state(input tick_state_e s);
    return (s != RUN);
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchroniser plus counter debouncer for one push-button.
// press_o pulses for one cycle after the stable level falls 1->0.
module key_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 32'd4,
  parameter logic        RESET_LEVEL     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  output logic stable_o,
  output logic press_o
);

  localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state: accept a new level only after it has differed for DEBOUNCE_CYCLES clocks
  always_comb begin
    sync1_d  = key_i;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        cnt_d    = {CNT_W{1'b0}};
      end else begin
        cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
    press_d = stable_q & ~stable_d;
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= RESET_LEVEL;
      sync2_q  <= RESET_LEVEL;
      stable_q <= RESET_LEVEL;
      press_q  <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
  assign press_o  = press_q;

endmodule

// File: rtl/frame_tick_generator.sv
// Game tick source: one-cycle tick per (frame_div+1) frame events in run mode, per key press in step mode.
// Define FRAME_TICK_AUTOREPEAT_EN to autorepeat a held key after REPEAT_DELAY frame events.
module frame_tick_generator
  import tick_gen_pkg::*;
#(
  parameter int unsigned COORD_W         = 32'd10,
  parameter int unsigned H_LAST          = H_LAST_DEF,
  parameter int unsigned V_LAST          = V_LAST_DEF,
  parameter int unsigned DIV_W           = 32'd4,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = 32'd16,
  parameter int unsigned REPEAT_DELAY    = 32'd30
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               step_mode_sw,
  input  logic               key_n,
  input  logic               pause,
  input  logic [COORD_W-1:0] pixel_x,
  input  logic [COORD_W-1:0] pixel_y,
  input  logic [DIV_W-1:0]   frame_div,
  output logic               tick,
  output logic [CNT_W-1:0]   tick_count,
  output logic               mode_is_step
);

  if (DEBOUNCE_CYCLES < 32'd2 || REPEAT_DELAY < 32'd1) begin : g_param_guard
    $error("frame_tick_generator: DEBOUNCE_CYCLES must be >= 2 and REPEAT_DELAY >= 1");
  end

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_LAST);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_LAST);

  logic              sw_meta_q, sw_sync_q;
  logic              key_stable_s, key_press_s;
  logic              frame_end_s, frame_end_q, frame_event_s;
  logic              mode_change_s, repeat_fire_s;
  tick_state_e       state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              tick_q, tick_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              mode_q, mode_d;

  key_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .RESET_LEVEL     (1'b1)
  ) u_key_db (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_i    (key_n),
    .stable_o (key_stable_s),
    .press_o  (key_press_s)
  );

  assign frame_end_s   = (pixel_x == X_LAST) && (pixel_y == Y_LAST);
  assign frame_event_s = frame_end_s & ~frame_end_q;

  // Mode FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (sw_sync_q) state_d = STEP_IDLE;
        else           state_d = RUN;
      end
      STEP_IDLE: begin
        if (!sw_sync_q)       state_d = RUN;
        else if (key_press_s) state_d = STEP_HELD;
        else                  state_d = STEP_IDLE;
      end
      STEP_HELD: begin
        if (!sw_sync_q)        state_d = RUN;
        else if (key_stable_s) state_d = STEP_IDLE;
        else                   state_d = STEP_HELD;
      end
      default: state_d = RUN;
    endcase
    mode_d        = is_step_state(state_d);
    mode_change_s = (is_step_state(state_q) != is_step_state(state_d));
  end

`ifdef FRAME_TICK_AUTOREPEAT_EN
  localparam int unsigned       HOLD_W    = $clog2(REPEAT_DELAY + 32'd1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(REPEAT_DELAY);

  logic [HOLD_W-1:0] hold_q, hold_d;

  // Hold counter: counts frame events while the key stays held, saturating at REPEAT_DELAY
  always_comb begin
    hold_d        = hold_q;
    repeat_fire_s = 1'b0;
    if (state_q == STEP_HELD && state_d == STEP_HELD) begin
      if (frame_event_s) begin
        if (hold_q == HOLD_LAST) begin
          repeat_fire_s = 1'b1;
        end else begin
          hold_d = hold_q + {{(HOLD_W-1){1'b0}}, 1'b1};
        end
      end else begin
        hold_d = hold_q;
      end
    end else begin
      hold_d = {HOLD_W{1'b0}};
    end
  end

  // Hold counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_q <= {HOLD_W{1'b0}};
    else        hold_q <= hold_d;
  end
`else
  assign repeat_fire_s = 1'b0;
`endif

  // Tick and divider: only the current state's source counts, nothing fires on a mode change
  always_comb begin
    div_d  = div_q;
    tick_d = 1'b0;
    if (mode_change_s) begin
      div_d = {DIV_W{1'b0}};
    end else if (pause) begin
      div_d = div_q;
    end else if (state_q == RUN && frame_event_s) begin
      if (div_q >= frame_div) begin
        tick_d = 1'b1;
        div_d  = {DIV_W{1'b0}};
      end else begin
        div_d  = div_q + {{(DIV_W-1){1'b0}}, 1'b1};
      end
    end else if (state_q == STEP_IDLE && key_press_s) begin
      tick_d = 1'b1;
    end else if (repeat_fire_s) begin
      tick_d = 1'b1;
    end else begin
      tick_d = 1'b0;
    end
    if (tick_d) count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    else        count_d = count_q;
  end

  // State registers; frame_end_q resets high so a pixel parked on the last coordinate cannot fire at release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_q   <= 1'b0;
      sw_sync_q   <= 1'b0;
      frame_end_q <= 1'b1;
      state_q     <= RUN;
      div_q       <= {DIV_W{1'b0}};
      tick_q      <= 1'b0;
      count_q     <= {CNT_W{1'b0}};
      mode_q      <= 1'b0;
    end else begin
      sw_meta_q   <= step_mode_sw;
      sw_sync_q   <= sw_meta_q;
      frame_end_q <= frame_end_s;
      state_q     <= state_d;
      div_q       <= div_d;
      tick_q      <= tick_d;
      count_q     <= count_d;
      mode_q      <= mode_d;
    end
  end

  assign tick         = tick_q;
  assign tick_count   = count_q;
  assign mode_is_step = mode_q;

endmodule

// File: tb/tb_frame_tick_generator.sv
// Self-checking bench for frame_tick_generator (DEBOUNCE_CYCLES=4, REPEAT_DELAY=3).
module tb_frame_tick_generator;

  localparam int unsigned DEB = 4;
  localparam int unsigned RD  = 3;

  logic        clk;
  logic        rst_n;
  logic        step_mode_sw;
  logic        key_n;
  logic        pause;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic [3:0]  frame_div;
  logic        tick;
  logic [15:0] tick_count;
  logic        mode_is_step;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int tick_q[$];
  int exp_q[$];
  int model_since = 0;
  int model_cnt   = 0;

  frame_tick_generator #(
    .COORD_W(10), .H_LAST(639), .V_LAST(479), .DIV_W(4),
    .DEBOUNCE_CYCLES(DEB), .CNT_W(16), .REPEAT_DELAY(RD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .step_mode_sw(step_mode_sw), .key_n(key_n),
    .pause(pause), .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_div(frame_div),
    .tick(tick), .tick_count(tick_count), .mode_is_step(mode_is_step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (tick === 1'b1) tick_q.push_back(cyc);

  task automatic step_clk(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Put the raster on the last visible pixel for 'hold' clocks; ev is the cycle the match appeared
  task automatic frame(input int hold, output int ev);
    pixel_x = 10'd639; pixel_y = 10'd479; ev = cyc;
    step_clk(hold);
    pixel_x = 10'd0; pixel_y = 10'd0;
  endtask

  // Reference rule for run mode: a tick every (frame_div+1) events, '>=' tolerates frame_div changes
  task automatic run_event(input int ev);
    if (!pause) begin
      if (model_since >= int'(frame_div)) begin
        exp_q.push_back(ev + 1); model_since = 0; model_cnt++;
      end else model_since++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; step_mode_sw = 1'b0; key_n = 1'b1; pause = 1'b0;
    pixel_x = 10'd0; pixel_y = 10'd0; frame_div = 4'd0;
    step_clk(3);
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", tick); end
    checks++; if (tick_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", tick_count); end
    checks++; if (mode_is_step !== 1'b0) begin errors++; $display("FAIL reset_mode: got %b expected 0", mode_is_step); end
    rst_n = 1'b1;
    step_clk(3);
    checks++; if (tick_q.size() != 0) begin errors++; $display("FAIL reset_release_tick: got %0d ticks expected 0", tick_q.size()); end
    model_since = 0; model_cnt = 0; tick_q.delete(); exp_q.delete();
  endtask

  task automatic test_run_div0;
    int ev;
    frame_div = 4'd0;
    for (int i = 0; i < 5; i++) begin frame(1, ev); run_event(ev); step_clk(999); end
    checks++;
    if (tick_q.size() != exp_q.size()) begin errors++; $display("FAIL div0_tick_num: got %0d expected %0d", tick_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      checks++; if (tick_q[i] != exp_q[i]) begin errors++; $display("FAIL div0_tick_cyc[%0d]: got %0d expected %0d", i, tick_q[i], exp_q[i]); end
    end
    checks++; if (tick_count !== 16'd5) begin errors++; $display("FAIL div0_count: got %0d expected 5", tick_count); end
    tick_q.delete(); exp_q.delete();
  endtask

  task automatic test_run_div2;
    int ev;
    frame_div = 4'd2;
    for (int i = 0; i < 9; i++) begin frame(4, ev); run_event(ev); step_clk(int'($urandom_range(10, 40))); end
    checks++;
    if (tick_q.size() != 3 || exp_q.size() != 3) begin errors++; $display("FAIL div2_tick_num: got %0d expected 3", tick_q.size()); end
    else foreach (exp_q[i]) begin
      checks++; if (tick_q[i] != exp_q[i]) begin errors++; $display("FAIL div2_tick_cyc[%0d]: got %0d expected %0d", i, tick_q[i], exp_q[i]); end
    end
    checks++; if (tick_count !== 16'(model_cnt)) begin errors++; $display("FAIL div2_count: got %0d expected %0d", tick_count, model_cnt); end
    tick_q.delete(); exp_q.delete();
  endtask

  task automatic test_run_random;
    int ev;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) frame_div = 4'($urandom_range(0, 5));
      frame(int'($urandom_range(1, 4)), ev); run_event(ev);
      step_clk(int'($urandom_range(3, 20)));
    end
    checks++;
    if (tick_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_tick_num: got %0d expected %0d", tick_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      checks++; if (tick_q[i] != exp_q[i]) begin errors++; $display("FAIL rand_tick_cyc[%0d]: got %0d expected %0d", i, tick_q[i], exp_q[i]); end
    end
    checks++; if (tick_count !== 16'(model_cnt)) begin errors++; $display("FAIL rand_count: got %0d expected %0d", tick_count, model_cnt); end
    tick_q.delete(); exp_q.delete();
  endtask

  task automatic test_mode_switch;
    int ev;
    frame_div = 4'd2;
    for (int k = 0; k < 4 && model_since != 1; k++) begin frame(1, ev); run_event(ev); step_clk(10); end
    step_mode_sw = 1'b1; step_clk(6); model_since = 0;
    checks++; if (mode_is_step !== 1'b1) begin errors++; $display("FAIL switch_mode_step: got %b expected 1", mode_is_step); end
    for (int i = 0; i < 2; i++) begin frame(1, ev); step_clk(10); end
    step_mode_sw = 1'b0; step_clk(6); model_since = 0;
    checks++; if (mode_is_step !== 1'b0) begin errors++; $display("FAIL switch_mode_run: got %b expected 0", mode_is_step); end
    for (int i = 0; i < 3; i++) begin frame(1, ev); run_event(ev); step_clk(10); end
    checks++;
    if (tick_q.size() != exp_q.size()) begin errors++; $display("FAIL switch_tick_num: got %0d expected %0d", tick_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      checks++; if (tick_q[i] != exp_q[i]) begin errors++; $display("FAIL switch_tick_cyc[%0d]: got %0d expected %0d", i, tick_q[i], exp_q[i]); end
    end
    tick_q.delete(); exp_q.delete();
  endtask

  task automatic test_step_press;
    int s, ev;
    step_mode_sw = 1'b1; step_clk(6);
    tick_q.delete();
    key_n = 1'b0; step_clk(1); key_n = 1'b1; step_clk(1);
    key_n = 1'b0; step_clk(1); key_n = 1'b1; step_clk(1);
    key_n = 1'b0; s = cyc; step_clk(12);
    key_n = 1'b1; step_clk(15);
    frame(2, ev); step_clk(10);
    model_cnt++;
    checks++; if (tick_q.size() != 1) begin errors++; $display("FAIL step_tick_num: got %0d expected 1", tick_q.size()); end
    checks++;
    if (tick_q.size() < 1 || tick_q[0] < s + 2 + int'(DEB) || tick_q[0] > s + 4 + int'(DEB)) begin
      errors++; $display("FAIL step_tick_cyc: got %0d expected %0d..%0d", (tick_q.size() > 0) ? tick_q[0] : -1, s + 2 + int'(DEB), s + 4 + int'(DEB));
    end
    checks++; if (tick_count !== 16'(model_cnt)) begin errors++; $display("FAIL step_count: got %0d expected %0d", tick_count, model_cnt); end
    tick_q.delete();
  endtask

  task automatic test_pause;
    int ev, n0;
    step_mode_sw = 1'b0; step_clk(6); model_since = 0; frame_div = 4'd2;
    tick_q.delete(); exp_q.delete();
    frame(1, ev); run_event(ev); step_clk(10);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin frame(1, ev); run_event(ev); step_clk(10); end
    key_n = 1'b0; step_clk(12); key_n = 1'b1; step_clk(12);
    pause = 1'b0;
    for (int i = 0; i < 2; i++) begin frame(1, ev); run_event(ev); step_clk(10); end
    checks++;
    if (tick_q.size() != 1 || exp_q.size() != 1) begin errors++; $display("FAIL pause_run_tick_num: got %0d expected 1", tick_q.size()); end
    else begin
      checks++; if (tick_q[0] != exp_q[0]) begin errors++; $display("FAIL pause_run_tick_cyc: got %0d expected %0d", tick_q[0], exp_q[0]); end
    end
    n0 = tick_q.size();
    step_mode_sw = 1'b1; step_clk(6);
    pause = 1'b1;
    key_n = 1'b0; step_clk(12); key_n = 1'b1; step_clk(12);
    pause = 1'b0; step_clk(5);
    checks++; if (tick_q.size() != n0) begin errors++; $display("FAIL pause_step_no_tick: got %0d ticks expected %0d", tick_q.size(), n0); end
    key_n = 1'b0; step_clk(12); key_n = 1'b1; step_clk(12);
    model_cnt++;
    checks++; if (tick_q.size() != n0 + 1) begin errors++; $display("FAIL pause_step_after: got %0d ticks expected %0d", tick_q.size(), n0 + 1); end
    checks++; if (tick_count !== 16'(model_cnt)) begin errors++; $display("FAIL pause_count: got %0d expected %0d", tick_count, model_cnt); end
    tick_q.delete(); exp_q.delete();
  endtask

  task automatic test_autorepeat;
    int s, exp_n;
    int ev[6];
    tick_q.delete();
    key_n = 1'b0; s = cyc; step_clk(12);
    for (int i = 0; i < 6; i++) begin frame(1, ev[i]); step_clk(15); end
    key_n = 1'b1; step_clk(15);
`ifdef FRAME_TICK_AUTOREPEAT_EN
    exp_n = 1 + 6 - int'(RD);
`else
    exp_n = 1;
`endif
    model_cnt += exp_n;
    checks++; if (tick_q.size() != exp_n) begin errors++; $display("FAIL hold_tick_num: got %0d expected %0d", tick_q.size(), exp_n); end
    else begin
      checks++;
      if (tick_q[0] < s + 2 + int'(DEB) || tick_q[0] > s + 4 + int'(DEB)) begin
        errors++; $display("FAIL hold_press_cyc: got %0d expected %0d..%0d", tick_q[0], s + 2 + int'(DEB), s + 4 + int'(DEB));
      end
      for (int i = 1; i < exp_n; i++) begin
        checks++;
        if (tick_q[i] != ev[int'(RD) + i - 1] + 1) begin
          errors++; $display("FAIL hold_repeat_cyc[%0d]: got %0d expected %0d", i, tick_q[i], ev[int'(RD) + i - 1] + 1);
        end
      end
    end
    checks++; if (tick_count !== 16'(model_cnt)) begin errors++; $display("FAIL hold_count: got %0d expected %0d", tick_count, model_cnt); end
    tick_q.delete();
  endtask

  task automatic test_reset_mid;
    int ev;
    step_mode_sw = 1'b0; step_clk(6); model_since = 0; frame_div = 4'd3;
    for (int i = 0; i < 2; i++) begin frame(1, ev); run_event(ev); step_clk(10); end
    key_n = 1'b0; step_clk(2);
    rst_n = 1'b0; #1;
    checks++; if (tick_count !== 16'd0) begin errors++; $display("FAIL midreset_count: got %0d expected 0", tick_count); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL midreset_tick: got %b expected 0", tick); end
    key_n = 1'b1; step_clk(2);
    rst_n = 1'b1; step_clk(1);
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL midreset_release_tick: got %b expected 0", tick); end
    model_since = 0; model_cnt = 0; tick_q.delete(); exp_q.delete();
    for (int i = 0; i < 4; i++) begin frame(1, ev); run_event(ev); step_clk(10); end
    checks++;
    if (tick_q.size() != 1 || exp_q.size() != 1) begin errors++; $display("FAIL midreset_tick_num: got %0d expected 1", tick_q.size()); end
    else begin
      checks++; if (tick_q[0] != exp_q[0]) begin errors++; $display("FAIL midreset_tick_cyc: got %0d expected %0d", tick_q[0], exp_q[0]); end
    end
    checks++; if (tick_count !== 16'd1) begin errors++; $display("FAIL midreset_count_after: got %0d expected 1", tick_count); end
  endtask

  initial begin
    test_reset();
    test_run_div0();
    test_run_div2();
    test_run_random();
    test_mode_switch();
    test_step_press();
    test_pause();
    test_autorepeat();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
